// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared types and line-state constants for the USB receive path.
// Revision    : 1.0
// ============================================================================
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACTIVE = 2'd1,
        EOP    = 2'd2
    } rx_state_t;

    localparam logic c_LINE_J = 1'b1;
    localparam logic c_LINE_K = 1'b0;

endpackage : usb_rx_pkg
`default_nettype wire

// File: rtl/syn_detector.sv
`default_nettype none
// ============================================================================
// Module      : syn_detector
// Description : USB receive SYNC/EOP detector; holds syn_out for a packet.
// Revision    : 1.0
// ============================================================================
module syn_detector
    import usb_rx_pkg::*;
#(
    parameter int MIN_ZEROS = 6,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic in_data,
    input  logic diff,
    output logic syn_out,
    output logic se0
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_MIN = CNT_W'(MIN_ZEROS);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_syn;
    logic             w_syn_nxt;
    logic             r_se0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_syn   <= 1'b0;
            r_se0   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_syn   <= w_syn_nxt;
            r_se0   <= ~diff;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_syn_nxt   = r_syn;
        case (r_state)
            HUNT: begin
                w_syn_nxt = 1'b0;
                if (!diff) begin
                    w_cnt_nxt = '0;
                end else if (in_data == c_LINE_K) begin
                    if (r_cnt != c_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end else begin
                    // The terminating 1 of SYNC; any shorter zero run is noise.
                    w_cnt_nxt = '0;
                    if (r_cnt >= c_CNT_MIN) begin
                        w_state_nxt = ACTIVE;
                        w_syn_nxt   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                w_syn_nxt = 1'b1;
                w_cnt_nxt = '0;
                if (!diff) begin
                    w_state_nxt = EOP;
                end
            end
            EOP: begin
                if (diff) begin
                    w_state_nxt = HUNT;
                    w_syn_nxt   = 1'b0;
                    // A K instead of J after SE0 is already the first zero of a new SYNC.
                    w_cnt_nxt   = (in_data == c_LINE_J) ? '0 : c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
                w_syn_nxt   = 1'b0;
            end
        endcase
    end

    assign syn_out = r_syn;
    assign se0     = r_se0;

endmodule : syn_detector
`default_nettype wire

// File: tb/tb_syn_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_syn_detector
// Description : Directed self-checking bench for syn_detector.
// Revision    : 1.0
// ============================================================================
module tb_syn_detector;

    logic clk;
    logic reset;
    logic in_data;
    logic diff;
    logic syn_out;
    logic se0;

    int checks;
    int errors;

    syn_detector #(
        .MIN_ZEROS (6),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .diff    (diff),
        .syn_out (syn_out),
        .se0     (se0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one line sample, clock it in, and settle just after the edge.
    task automatic step(input logic d, input logic x);
        diff    = d;
        in_data = x;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
            checks++;
            if (syn_out !== 1'b0 || se0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: syn_out=%b se0=%b expected 0 0", i, syn_out, se0);
            end
        end
        reset = 1'b0;
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b0 || se0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: syn_out=%b se0=%b expected 0 0", syn_out, se0);
        end
    endtask

    task automatic test_basic_sync();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (syn_out !== 1'b0 || se0 !== 1'b0) begin
                errors++;
                $display("FAIL basic_zero[%0d]: syn_out=%b se0=%b expected 0 0", i, syn_out, se0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (syn_out !== 1'b1 || se0 !== 1'b0) begin
                errors++;
                $display("FAIL basic_one[%0d]: syn_out=%b se0=%b expected 1 0", i, syn_out, se0);
            end
        end
    endtask

    task automatic test_eop();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (syn_out !== 1'b1 || se0 !== 1'b1) begin
                errors++;
                $display("FAIL eop_se0[%0d]: syn_out=%b se0=%b expected 1 1", i, syn_out, se0);
            end
        end
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b0 || se0 !== 1'b0) begin
            errors++;
            $display("FAIL eop_j: syn_out=%b se0=%b expected 0 0", syn_out, se0);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        checks++;
        if (syn_out !== 1'b0) begin
            errors++;
            $display("FAIL eop_resync_zeros: syn_out=%b expected 0", syn_out);
        end
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b1) begin
            errors++;
            $display("FAIL eop_resync: syn_out=%b expected 1", syn_out);
        end
    endtask

    task automatic test_active_ignores_data();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b1) begin
            errors++;
            $display("FAIL active_hold: syn_out=%b expected 1", syn_out);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        step(1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if (syn_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: syn_out=%b expected 0", syn_out);
        end
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_one: syn_out=%b expected 0", syn_out);
        end
    endtask

    task automatic test_short_sync();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b0) begin
            errors++;
            $display("FAIL short_sync: syn_out=%b expected 0", syn_out);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b1) begin
            errors++;
            $display("FAIL min_sync: syn_out=%b expected 1", syn_out);
        end
    endtask

    task automatic test_se0_hunt();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (se0 !== 1'b1 || syn_out !== 1'b0) begin
            errors++;
            $display("FAIL hunt_se0: se0=%b syn_out=%b expected 1 0", se0, syn_out);
        end
        step(1'b1, 1'b0);
        checks++;
        if (se0 !== 1'b0) begin
            errors++;
            $display("FAIL hunt_se0_end: se0=%b expected 0", se0);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b0) begin
            errors++;
            $display("FAIL hunt_se0_clear: syn_out=%b expected 0", syn_out);
        end
    endtask

    task automatic test_malformed_eop();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (syn_out !== 1'b0 || se0 !== 1'b0) begin
            errors++;
            $display("FAIL bad_eop_k: syn_out=%b se0=%b expected 0 0", syn_out, se0);
        end
        // The K already counts, so five more zeros complete the run of six.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b1) begin
            errors++;
            $display("FAIL bad_eop_resync: syn_out=%b expected 1", syn_out);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (syn_out !== 1'b1) begin
            errors++;
            $display("FAIL long_sync: syn_out=%b expected 1", syn_out);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        diff    = 1'b1;
        in_data = 1'b1;
        test_reset();
        test_basic_sync();
        test_eop();
        test_active_ignores_data();
        test_mid_reset();
        test_short_sync();
        test_se0_hunt();
        test_malformed_eop();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_syn_detector
`default_nettype wire
